param_regfile: RTL
==================

PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning register data width in bits (>=1).
REQ-002 SHALL provide parameter DEPTH, default 16, meaning register count (power of 2, >=4); AW = log2(DEPTH).
REQ-003 SHALL have the ports below, one clock and one reset; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 rd_addr1, rd_addr2  in  AW  read port addresses.
REQ-007 rd_data1, rd_data2  out  WIDTH  read port data, combinational.
REQ-008 wr_en  in  1; wr_addr  in  AW; wr_data  in  WIDTH  write port.
REQ-009 clr_req  in  1  request a bulk clear of all registers.
REQ-010 clr_busy  out  1  clear sequence in progress.
REQ-011 clr_done  out  1  one-cycle pulse when the clear completes.
REQ-012 sb_set  in  1; sb_set_addr  in  AW  mark a register pending (producer issued).
REQ-013 sb_pend1, sb_pend2  out  1  pending status for rd_addr1 and rd_addr2.

Function
REQ-014 Register 0 SHALL read as zero and SHALL never be written or marked pending.
REQ-015 Reads SHALL have zero latency; writes SHALL take effect at the rising edge when wr_en=1, wr_addr!=0 and the FSM is IDLE.
REQ-016 Each register SHALL have one scoreboard bit: set at the edge when sb_set=1 (addr!=0, IDLE); cleared at the edge of a qualifying write to that address.
REQ-017 Simultaneous sb_set and qualifying write to the same address SHALL leave the bit set (set wins).
REQ-018 sb_pendN SHALL equal the scoreboard bit of rd_addrN, qualified per REQ-028/029.
REQ-019 Clear FSM SHALL have states IDLE, CLEAR, DONE.
REQ-020 IDLE->CLEAR at the edge where clr_req=1; index counter loads 1; all scoreboard bits clear at the same edge.
REQ-021 In CLEAR, each edge SHALL write zero to register[index] and increment index; at index=DEPTH-1 the write occurs and FSM moves to DONE (DEPTH-1 cycles in CLEAR).
REQ-022 DONE SHALL last exactly one cycle with clr_done=1, then return to IDLE; clr_req ignored outside IDLE.
REQ-023 clr_busy SHALL be 1 in CLEAR and DONE, 0 in IDLE.
REQ-024 While clr_busy=1, wr_en and sb_set SHALL be ignored; reads return current storage (partially cleared allowed).
REQ-025 clr_req and wr_en in the same IDLE cycle: the write SHALL complete, then the clear sequence overwrites it.

Reset
REQ-026 When rst=0 at an edge, all registers, scoreboard bits and index SHALL go to 0 and the FSM to IDLE; clr_busy=0, clr_done=0.
REQ-027 Reset mid-CLEAR SHALL abort the sequence with no clr_done pulse.

Configuration
REQ-028 With REGFILE_BYPASS_EN defined, a read whose address equals wr_addr during a qualifying write (REQ-015) SHALL return wr_data, and sb_pend for that port SHALL be 0.
REQ-029 Without REGFILE_BYPASS_EN, reads SHALL return stored contents only (new value visible the cycle after the edge), and sb_pend SHALL be the raw scoreboard bit.

Verification
REQ-030 Reset, then write 16'hBEEF to r5, read r5 next cycle -> rd_data1=16'hBEEF; write r0=16'h1234 -> rd_data reads 16'h0000.
REQ-031 Same-cycle wr r7=16'hA5A5 with rd_addr2=7 -> 16'hA5A5 with REGFILE_BYPASS_EN, old value 16'h0000 without.
REQ-032 sb_set r3, next cycle sb_pend1(rd_addr1=3)=1; write r3 -> pend 0 after edge; same-cycle set+write r3 -> pend stays 1.
REQ-033 DEPTH=16: fill r1..r15 nonzero, pulse clr_req -> clr_busy high 16 cycles, clr_done pulse on 16th cycle after request edge, all reads 0, wr_en during busy discarded.
REQ-034 Assert rst=0 on 5th CLEAR cycle -> FSM IDLE, all registers 0, no clr_done pulse.

Source files
------------

// File: rtl/param_regfile_if.sv
// Bus interface for param_regfile: read ports, write port, bulk-clear handshake
// and scoreboard set/status. The master modport belongs to the client and the
// slave modport belongs to the register file.
interface param_regfile_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    rd_addr1;
  logic [AW-1:0]    rd_addr2;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr_req;
  logic             clr_busy;
  logic             clr_done;
  logic             sb_set;
  logic [AW-1:0]    sb_set_addr;
  logic             sb_pend1;
  logic             sb_pend2;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req, sb_set, sb_set_addr,
    input  rd_data1, rd_data2, clr_busy, clr_done, sb_pend1, sb_pend2
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req, sb_set, sb_set_addr,
    output rd_data1, rd_data2, clr_busy, clr_done, sb_pend1, sb_pend2
  );
endinterface

// File: rtl/param_regfile.sv
// param_regfile: two-read / one-write register file with a per-register pending
// scoreboard and a sequential bulk-clear engine (IDLE -> CLEAR -> DONE).
// Register 0 is hardwired to zero and can never be marked pending.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle qualifying write to
// the read ports and reports that register as not pending.
module param_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input logic           clk,
  input logic           rst,
  param_regfile_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_idx;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_sb;

  logic             w_idle;
  logic             w_start;
  logic             w_wr_ok;
  logic             w_sb_ok;
  logic             w_last;
  logic [WIDTH-1:0] w_raw1;
  logic [WIDTH-1:0] w_raw2;

  assign w_idle  = (r_state == IDLE);
  assign w_start = w_idle && bus.clr_req;
  assign w_wr_ok = w_idle && bus.wr_en && (bus.wr_addr != '0);
  assign w_sb_ok = w_idle && bus.sb_set && (bus.sb_set_addr != '0);
  assign w_last  = (r_idx == AW'(DEPTH - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.clr_req) w_next = CLEAR;
      CLEAR:   if (w_last)      w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.clr_busy = (r_state != IDLE);
    bus.clr_done = (r_state == DONE);
  end

  // Clear index: starts at 1 so register 0 is never touched
  always_ff @(posedge clk) begin
    if (!rst)                  r_idx <= '0;
    else if (w_start)          r_idx <= AW'(1);
    else if (r_state == CLEAR) r_idx <= r_idx + AW'(1);
  end

  // Storage: client write first, then clear engine; in IDLE both cannot coincide
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr_ok)            r_mem[bus.wr_addr] <= bus.wr_data;
      if (r_state == CLEAR)   r_mem[r_idx]       <= '0;
    end
  end

  // Scoreboard: clear-start wipes all bits; otherwise write clears and set wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sb <= '0;
    end else if (w_start) begin
      r_sb <= '0;
    end else begin
      if (w_wr_ok) r_sb[bus.wr_addr]     <= 1'b0;
      if (w_sb_ok) r_sb[bus.sb_set_addr] <= 1'b1;
    end
  end

  // Combinational read of stored contents, register 0 forced to zero
  always_comb begin
    w_raw1 = (bus.rd_addr1 == '0) ? '0 : r_mem[bus.rd_addr1];
    w_raw2 = (bus.rd_addr2 == '0) ? '0 : r_mem[bus.rd_addr2];
  end

`ifdef REGFILE_BYPASS_EN
  // Read ports with write forwarding
  always_comb begin
    bus.rd_data1 = w_raw1;
    bus.rd_data2 = w_raw2;
    bus.sb_pend1 = r_sb[bus.rd_addr1];
    bus.sb_pend2 = r_sb[bus.rd_addr2];
    if (w_wr_ok && (bus.rd_addr1 == bus.wr_addr)) begin
      bus.rd_data1 = bus.wr_data;
      bus.sb_pend1 = 1'b0;
    end
    if (w_wr_ok && (bus.rd_addr2 == bus.wr_addr)) begin
      bus.rd_data2 = bus.wr_data;
      bus.sb_pend2 = 1'b0;
    end
  end
`else
  // Read ports return stored contents and raw scoreboard bits
  always_comb begin
    bus.rd_data1 = w_raw1;
    bus.rd_data2 = w_raw2;
    bus.sb_pend1 = r_sb[bus.rd_addr1];
    bus.sb_pend2 = r_sb[bus.rd_addr2];
  end
`endif

endmodule
